// File: rtl/clock_ctl_pkg.sv
// Shared types and helpers for the reference-clock switchover sequencer.
package clock_ctl_pkg;

  typedef enum logic [2:0] {
    SW_IDLE,
    SW_PULSE,
    SW_WAIT,
    SW_HOLDOFF,
    SW_FAULT
  } sw_state_t;

  typedef enum logic {
    CLK_MASTER = 1'b0,
    CLK_SLAVE  = 1'b1
  } clk_sel_t;

  // Bits needed to hold values 0..maxValue, never less than one.
  function automatic int cntWidth(input int maxValue);
    return (maxValue < 2) ? 1 : $clog2(maxValue + 1);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous status bit; resets to 0.
module bit_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic asyncIn,
  output logic syncOut
);

  logic metaFlop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      metaFlop <= 1'b0;
      syncOut  <= 1'b0;
    end else begin
      metaFlop <= asyncIn;
      syncOut  <= metaFlop;
    end
  end

endmodule

// File: rtl/clock_switch_sequencer.sv
// Master/slave reference-clock switchover sequencer for the PLL clk_switch input.
// Optional feature: define CLOCK_SWITCH_STATS_EN to add switch_count / fail_count outputs.
module clock_switch_sequencer
  import clock_ctl_pkg::*;
#(
  parameter int GOOD_CYCLES    = 1024,
  parameter int PULSE_CYCLES   = 4,
  parameter int SETTLE_CYCLES  = 256,
  parameter int HOLDOFF_CYCLES = 64,
  parameter int RETRY_LIMIT    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        allow_slave,
  input  logic        active_clock,
  input  logic        slave_clock_bad,
  input  logic        fault_clear,
  output logic        clk_switch,
  output logic        busy,
  output logic        on_slave,
  output logic        slave_ok,
  output logic        fault
`ifdef CLOCK_SWITCH_STATS_EN
  ,
  output logic [15:0] switch_count,
  output logic [7:0]  fail_count
`endif
);

  localparam int GOOD_W   = cntWidth(GOOD_CYCLES);
  localparam int PULSE_W  = cntWidth(PULSE_CYCLES);
  localparam int SETTLE_W = cntWidth(SETTLE_CYCLES);
  localparam int HOLD_W   = cntWidth(HOLDOFF_CYCLES);
  localparam int RETRY_W  = cntWidth(RETRY_LIMIT);

  localparam logic [GOOD_W-1:0]   GOOD_MAX    = GOOD_W'(GOOD_CYCLES);
  localparam logic [PULSE_W-1:0]  PULSE_LOAD  = PULSE_W'(PULSE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LOAD   = HOLD_W'(HOLDOFF_CYCLES - 1);
  localparam logic [RETRY_W-1:0]  RETRY_MAX   = RETRY_W'(RETRY_LIMIT);

  sw_state_t            state;
  clk_sel_t             expectedSel;
  clk_sel_t             currentSel;
  clk_sel_t             targetSel;
  logic                 activeSync;
  logic                 slaveBadSync;
  logic [GOOD_W-1:0]    goodCnt;
  logic [PULSE_W-1:0]   pulseCnt;
  logic [SETTLE_W-1:0]  settleCnt;
  logic [HOLD_W-1:0]    holdCnt;
  logic [RETRY_W-1:0]   retryCnt;
  logic [RETRY_W-1:0]   retryNext;
  logic                 request;
  logic                 attemptOk;
  logic                 attemptTimeout;

  bit_sync uActiveSync (
    .clk     (clk),
    .reset_n (reset_n),
    .asyncIn (active_clock),
    .syncOut (activeSync)
  );

  bit_sync uSlaveBadSync (
    .clk     (clk),
    .reset_n (reset_n),
    .asyncIn (slave_clock_bad),
    .syncOut (slaveBadSync)
  );

  assign on_slave = activeSync;

  // The slave must be continuously good for GOOD_CYCLES before we trust it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      goodCnt <= '0;
    end else if (slaveBadSync) begin
      goodCnt <= '0;
    end else if (goodCnt != GOOD_MAX) begin
      goodCnt <= goodCnt + GOOD_W'(1);
    end
  end

  assign slave_ok   = (goodCnt == GOOD_MAX);
  assign currentSel = clk_sel_t'(activeSync);
  assign targetSel  = (allow_slave && slave_ok) ? CLK_SLAVE : CLK_MASTER;

  // A bad slave suppresses requests entirely; leaving a dead slave is the PLL's job.
  assign request        = slave_ok && (currentSel != targetSel);
  assign attemptOk      = (state == SW_WAIT) && (currentSel == expectedSel);
  assign attemptTimeout = (state == SW_WAIT) && !attemptOk && (settleCnt == '0);
  assign retryNext      = retryCnt + RETRY_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SW_IDLE;
      expectedSel <= CLK_MASTER;
      pulseCnt    <= '0;
      settleCnt   <= '0;
      holdCnt     <= '0;
      retryCnt    <= '0;
      clk_switch  <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      unique case (state)
        SW_IDLE: begin
          if (request) begin
            expectedSel <= (currentSel == CLK_SLAVE) ? CLK_MASTER : CLK_SLAVE;
            pulseCnt    <= PULSE_LOAD;
            clk_switch  <= 1'b1;
            busy        <= 1'b1;
            state       <= SW_PULSE;
          end
        end
        SW_PULSE: begin
          if (pulseCnt == '0) begin
            clk_switch <= 1'b0;
            settleCnt  <= SETTLE_LOAD;
            state      <= SW_WAIT;
          end else begin
            pulseCnt <= pulseCnt - PULSE_W'(1);
          end
        end
        // A match on the final settle cycle still counts as success.
        SW_WAIT: begin
          if (attemptOk) begin
            retryCnt <= '0;
            holdCnt  <= HOLD_LOAD;
            state    <= SW_HOLDOFF;
          end else if (attemptTimeout) begin
            retryCnt <= retryNext;
            if (retryNext == RETRY_MAX) begin
              busy  <= 1'b0;
              fault <= 1'b1;
              state <= SW_FAULT;
            end else begin
              holdCnt <= HOLD_LOAD;
              state   <= SW_HOLDOFF;
            end
          end else begin
            settleCnt <= settleCnt - SETTLE_W'(1);
          end
        end
        SW_HOLDOFF: begin
          if (holdCnt == '0) begin
            busy  <= 1'b0;
            state <= SW_IDLE;
          end else begin
            holdCnt <= holdCnt - HOLD_W'(1);
          end
        end
        SW_FAULT: begin
          if (fault_clear) begin
            retryCnt <= '0;
            fault    <= 1'b0;
            state    <= SW_IDLE;
          end
        end
        default: begin
          state <= SW_IDLE;
        end
      endcase
    end
  end

`ifdef CLOCK_SWITCH_STATS_EN
  // Lifetime statistics survive fault_clear; only reset zeroes them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      switch_count <= '0;
      fail_count   <= '0;
    end else begin
      if (attemptOk && (switch_count != 16'hFFFF)) begin
        switch_count <= switch_count + 16'd1;
      end
      if (attemptTimeout && (fail_count != 8'hFF)) begin
        fail_count <= fail_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_clock_switch_sequencer.sv
// Directed/randomized bench for clock_switch_sequencer with a timing-rule reference model.
module tb_clock_switch_sequencer;

  localparam int G  = 1024;
  localparam int P  = 4;
  localparam int SE = 256;
  localparam int H  = 64;
  localparam int R  = 3;
  // Failed attempt: pulse, full settle window, holdoff, one IDLE cycle to re-request.
  localparam int T  = P + SE + H + 1;

  logic clk = 1'b0;
  logic reset_n;
  logic allow_slave;
  logic active_clock;
  logic slave_clock_bad;
  logic fault_clear;
  logic clk_switch;
  logic busy;
  logic on_slave;
  logic slave_ok;
  logic fault;
`ifdef CLOCK_SWITCH_STATS_EN
  logic [15:0] switch_count;
  logic [7:0]  fail_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulseStarts[$];
  int pulseWidths[$];
  logic prevSwitch = 1'b0;
  int curWidth = 0;

  clock_switch_sequencer #(
    .GOOD_CYCLES   (G),
    .PULSE_CYCLES  (P),
    .SETTLE_CYCLES (SE),
    .HOLDOFF_CYCLES(H),
    .RETRY_LIMIT   (R)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .allow_slave    (allow_slave),
    .active_clock   (active_clock),
    .slave_clock_bad(slave_clock_bad),
    .fault_clear    (fault_clear),
    .clk_switch     (clk_switch),
    .busy           (busy),
    .on_slave       (on_slave),
    .slave_ok       (slave_ok),
    .fault          (fault)
`ifdef CLOCK_SWITCH_STATS_EN
    ,
    .switch_count   (switch_count),
    .fail_count     (fail_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Records every clk_switch pulse (start cycle and width) seen at the sampling edge.
  always @(negedge clk) begin
    if (clk_switch && !prevSwitch) begin
      pulseStarts.push_back(cyc);
      curWidth = 1;
    end else if (clk_switch) begin
      curWidth++;
    end else if (prevSwitch) begin
      pulseWidths.push_back(curWidth);
    end
    prevSwitch = clk_switch;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic toCycle(input int n);
    if (cyc > n) begin
      errors++;
      $error("[TB] FAIL schedule: at cycle %0d observed, cycle %0d expected", cyc, n);
    end
    while (cyc < n) @(negedge clk);
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Status flip at cycle f is usable two cycles later; WAIT begins after the pulse.
  function automatic int matchCyc(input int s, input int f);
    return (f + 2 > s + P) ? f + 2 : s + P;
  endfunction

  task automatic checkPulses(input string tag, input int base, input int n, input int s1, input int step);
    checkOutput({tag, " count"}, pulseStarts.size() - base, n);
    for (int i = 0; i < n && base + i < pulseStarts.size(); i++) begin
      checkOutput({tag, " start"}, pulseStarts[base + i], s1 + i * step);
      if (base + i < pulseWidths.size()) checkOutput({tag, " width"}, pulseWidths[base + i], P);
    end
  endtask

  // Attempts that never see the PLL change over: three pulses then sticky fault.
  task automatic runToFault(input string tag, input int s1);
    int s3;
    s3 = s1 + 2 * T;
    toCycle(s1);
    checkOutput({tag, " pulse1"}, clk_switch, 1);
    toCycle(s1 + T - 1);
    checkOutput({tag, " idle busy"}, busy, 0);
    checkOutput({tag, " idle sw"}, clk_switch, 0);
    toCycle(s1 + T);
    checkOutput({tag, " pulse2"}, clk_switch, 1);
    toCycle(s1 + T + P + 5);
    fault_clear = 1'b1;
    toCycle(s1 + T + P + 6);
    fault_clear = 1'b0;
    toCycle(s3);
    checkOutput({tag, " pulse3"}, clk_switch, 1);
    toCycle(s3 + P + SE - 1);
    checkOutput({tag, " prefault"}, fault, 0);
    checkOutput({tag, " prefault busy"}, busy, 1);
    toCycle(s3 + P + SE);
    checkOutput({tag, " fault"}, fault, 1);
    checkOutput({tag, " fault busy"}, busy, 0);
  endtask

  initial begin
    int a, s, f, m, c, base;

    allow_slave     = 1'b0;
    active_clock    = 1'b0;
    slave_clock_bad = 1'b0;
    fault_clear     = 1'b0;
    reset_n         = 1'b0;
    @(negedge clk);
    applyReset();

    checkOutput("rst clk_switch", clk_switch, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst fault", fault, 0);
    checkOutput("rst slave_ok", slave_ok, 0);
    checkOutput("rst on_slave", on_slave, 0);

    // Qualification then switch to slave.
    base = pulseStarts.size();
    a = $urandom_range(10, 900);
    toCycle(a);
    allow_slave = 1'b1;
    toCycle(G - 1);
    checkOutput("q1 slave_ok early", slave_ok, 0);
    toCycle(G);
    checkOutput("q1 slave_ok", slave_ok, 1);
    checkOutput("q1 no pulse yet", clk_switch, 0);
    s = G + 1;
    toCycle(s);
    checkOutput("q1 pulse", clk_switch, 1);
    checkOutput("q1 busy", busy, 1);
    toCycle(s + P - 1);
    checkOutput("q1 pulse last", clk_switch, 1);
    toCycle(s + P);
    checkOutput("q1 pulse end", clk_switch, 0);
    f = s + 10;
    toCycle(f);
    active_clock = 1'b1;
    m = matchCyc(s, f);
    toCycle(m + H);
    checkOutput("q1 busy last", busy, 1);
    toCycle(m + H + 1);
    checkOutput("q1 busy end", busy, 0);
    checkOutput("q1 on_slave", on_slave, 1);
    checkOutput("q1 fault", fault, 0);
    toCycle(m + H + 50);
    checkPulses("q1", base, 1, s, 0);

    // Host withdraws permission: switch back to master.
    base = pulseStarts.size();
    a = cyc + $urandom_range(2, 20);
    toCycle(a);
    allow_slave = 1'b0;
    s = a + 1;
    toCycle(s);
    checkOutput("back pulse", clk_switch, 1);
    f = s + $urandom_range(1, P + SE - 3);
    toCycle(f);
    active_clock = 1'b0;
    m = matchCyc(s, f);
    toCycle(m + H);
    checkOutput("back busy last", busy, 1);
    toCycle(m + H + 1);
    checkOutput("back busy end", busy, 0);
    checkOutput("back on_slave", on_slave, 0);
    toCycle(m + H + 20);
    checkPulses("back", base, 1, s, 0);

    // PLL never responds: retries exhaust into fault, mid-attempt fault_clear ignored.
    base = pulseStarts.size();
    a = cyc + $urandom_range(2, 20);
    toCycle(a);
    allow_slave = 1'b1;
    s = a + 1;
    runToFault("flt1", s);
    toCycle(s + 2 * T + P + SE + T);
    checkPulses("flt1", base, R, s, T);
    checkOutput("flt1 sticky", fault, 1);
    c = cyc + $urandom_range(1, 10);
    toCycle(c);
    fault_clear = 1'b1;
    toCycle(c + 1);
    fault_clear = 1'b0;
    checkOutput("flt1 cleared", fault, 0);
    s = c + 2;
    toCycle(s);
    checkOutput("flt1 new pulse", clk_switch, 1);
    f = s + $urandom_range(1, P + SE - 3);
    toCycle(f);
    active_clock = 1'b1;
    m = matchCyc(s, f);
    toCycle(m + H + 1);
    checkOutput("flt1 recover busy", busy, 0);
    checkOutput("flt1 recover on_slave", on_slave, 1);

    // One-cycle bad glitch at count 1000 restarts qualification.
    active_clock = 1'b0;
    applyReset();
    base = pulseStarts.size();
    toCycle(998);
    slave_clock_bad = 1'b1;
    toCycle(999);
    slave_clock_bad = 1'b0;
    toCycle(G + 1);
    checkOutput("glitch no early pulse", clk_switch, 0);
    checkOutput("glitch slave_ok low", slave_ok, 0);
    toCycle(1000 + G);
    checkOutput("glitch slave_ok early", slave_ok, 0);
    toCycle(1001 + G);
    checkOutput("glitch slave_ok", slave_ok, 1);
    s = 1002 + G;
    toCycle(s);
    checkOutput("glitch pulse", clk_switch, 1);

    // Status arrives on the final settle cycle: success, no retry.
    f = s + P + SE - 3;
    toCycle(f);
    active_clock = 1'b1;
    m = matchCyc(s, f);
    toCycle(m - 1);
    checkOutput("edge on_slave early", on_slave, 0);
    checkOutput("edge busy", busy, 1);
    toCycle(m);
    checkOutput("edge on_slave", on_slave, 1);
    toCycle(m + H + 1);
    checkOutput("edge busy end", busy, 0);
    checkOutput("edge fault", fault, 0);
    toCycle(s + T + 10);
    checkPulses("edge", base, 1, s, 0);

    // Retry count must be clean: a full three attempts before fault again.
    base = pulseStarts.size();
    a = cyc + $urandom_range(2, 20);
    toCycle(a);
    allow_slave = 1'b0;
    s = a + 1;
    runToFault("flt2", s);
    checkPulses("flt2", base, R, s, T);

    // Reset asserted mid-pulse.
    c = cyc + $urandom_range(1, 10);
    toCycle(c);
    fault_clear = 1'b1;
    toCycle(c + 1);
    fault_clear = 1'b0;
    toCycle(c + 3);
    checkOutput("midrst pulse", clk_switch, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst clk_switch", clk_switch, 0);
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst fault", fault, 0);
    checkOutput("midrst slave_ok", slave_ok, 0);
    checkOutput("midrst on_slave", on_slave, 0);
`ifdef CLOCK_SWITCH_STATS_EN
    checkOutput("midrst switch_count", switch_count, 0);
    checkOutput("midrst fail_count", fail_count, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("post rst clk_switch", clk_switch, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
